// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Define DIV_SELFCHECK_EN to add a registered q*d + r == n consistency check on check_err.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
`ifdef DIV_SELFCHECK_EN
  ,
  output logic             check_err
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   n_q, n_d;     // dividend shift register
  logic [WIDTH-1:0]   d_q, d_d;     // latched divisor
  logic [WIDTH-1:0]   r_q, r_d;     // partial remainder, always < divisor
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   diff;
  logic               fits;

  // The trial value is one bit wider than the remainder; when it fits, the
  // difference is below the divisor, so WIDTH bits of it are exact.
  assign trial = {r_q, n_q[WIDTH-1]};
  assign fits  = (trial >= {1'b0, d_q});
  assign diff  = trial[WIDTH-1:0] - d_q;

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d   = dividend;
          d_d   = divisor;
          cnt_d = CNT_W'(WIDTH);
          if (divisor == '0) begin
            q_d     = '1;
            r_d     = dividend;
            dbz_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            q_d     = '0;
            r_d     = '0;
            dbz_d   = 1'b0;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        n_d   = {n_q[WIDTH-2:0], 1'b0};
        r_d   = fits ? diff : trial[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], fits};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      d_q     <= d_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_FIN);
  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = dbz_q;

`ifdef DIV_SELFCHECK_EN
  // The shift register consumes the dividend, so a pristine copy is kept.
  logic [WIDTH-1:0]   n_orig_q, n_orig_d;
  logic               chk_q, chk_d;
  logic [2*WIDTH-1:0] recon;
  logic               bad;

  assign recon = (2*WIDTH)'(q_q) * (2*WIDTH)'(d_q) + (2*WIDTH)'(r_q);
  assign bad   = (recon != (2*WIDTH)'(n_orig_q)) || (r_q >= d_q);

  always_comb begin
    n_orig_d = n_orig_q;
    chk_d    = chk_q;
    if (state_q == S_IDLE && start) begin
      n_orig_d = dividend;
      chk_d    = 1'b0;
    end else if (state_q == S_FIN && !dbz_q) begin
      chk_d = bad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_orig_q <= '0;
      chk_q    <= 1'b0;
    end else begin
      n_orig_q <= n_orig_d;
      chk_q    <= chk_d;
    end
  end

  assign check_err = chk_q;
`endif

  a_busy_done_excl : assert property (@(posedge clk) disable iff (!rst_n) !(busy && done));
  a_done_pulse     : assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=4): vector table, exhaustive and
// random sweeps against a plain-arithmetic model, plus handshake corner sequences.
module tb_seq_divider;

  localparam int W = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
`ifdef DIV_SELFCHECK_EN
  logic         check_err;
`endif

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
`ifdef DIV_SELFCHECK_EN
    ,
    .check_err   (check_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Reference: unsigned division by the arithmetic rules, with the divide-by-zero convention.
  function automatic void ref_div(input int n, input int d, output int q, output int r,
                                  output int dbz);
    if (d == 0) begin
      q = MAXV; r = n; dbz = 1;
    end else begin
      q = n / d; r = n % d; dbz = 0;
    end
  endfunction

  // Called on the negedge of cycle first_cyc after the accept edge.
  task automatic wait_done(input int first_cyc, output int lat, output int busy_cycles);
    int cyc;
    cyc = first_cyc;
    lat = -1;
    busy_cycles = 0;
    while (cyc < first_cyc + 40) begin
      if (done) begin
        lat = cyc;
        break;
      end
      if (busy) busy_cycles++;
      @(negedge clk);
      cyc++;
    end
  endtask

  // Called on an IDLE negedge; returns on the IDLE negedge after FIN.
  task automatic run_div(input int n, input int d, output int q, output int r, output int dbz,
                         output int lat, output int busy_cycles);
    start    = 1'b1;
    dividend = W'(n);
    divisor  = W'(d);
    @(negedge clk);
    start    = 1'b0;
    wait_done(1, lat, busy_cycles);
    q   = int'(quotient);
    r   = int'(remainder);
    dbz = int'(div_by_zero);
    @(negedge clk);
  endtask

  typedef struct {
    int n;
    int d;
    int q;
    int r;
    int dbz;
    int lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int q, r, dbz, lat, bc, eq, er, edbz;
    int done_cnt, lat1, lat2, q1, r1, q2, r2;

    vecs[0] = '{13, 3, 4, 1, 0, 5};
    vecs[1] = '{15, 1, 15, 0, 0, 5};
    vecs[2] = '{2, 9, 0, 2, 0, 5};
    vecs[3] = '{15, 15, 1, 0, 0, 5};
    vecs[4] = '{0, 5, 0, 0, 0, 5};
    vecs[5] = '{7, 0, 15, 7, 1, 1};
    vecs[6] = '{9, 2, 4, 1, 0, 5};

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;

    // Reset state, during and after reset with no start.
    #3;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_q", int'(quotient), 0);
    check("rst_r", int'(remainder), 0);
    check("rst_dbz", int'(div_by_zero), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    dividend = 4'd13; divisor = 4'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_busy", int'(busy), 0);
      check("idle_done", int'(done), 0);
      check("idle_q", int'(quotient), 0);
      check("idle_r", int'(remainder), 0);
    end

    // Vector table, with result hold after done.
    for (int i = 0; i < 7; i++) begin
      run_div(vecs[i].n, vecs[i].d, q, r, dbz, lat, bc);
      check("vec_q", q, vecs[i].q);
      check("vec_r", r, vecs[i].r);
      check("vec_dbz", dbz, vecs[i].dbz);
      check("vec_lat", lat, vecs[i].lat);
      check("vec_busy_cycles", bc, vecs[i].lat - 1);
      dividend = W'($urandom); divisor = W'($urandom);
      @(negedge clk); @(negedge clk);
      check("hold_q", int'(quotient), vecs[i].q);
      check("hold_r", int'(remainder), vecs[i].r);
      check("hold_dbz", int'(div_by_zero), vecs[i].dbz);
      check("hold_done", int'(done), 0);
    end

    // Exhaustive nonzero-divisor sweep.
    for (int n = 0; n <= MAXV; n++) begin
      for (int d = 1; d <= MAXV; d++) begin
        ref_div(n, d, eq, er, edbz);
        run_div(n, d, q, r, dbz, lat, bc);
        check("sweep_q", q, eq);
        check("sweep_r", r, er);
        check("sweep_dbz", dbz, edbz);
`ifdef DIV_SELFCHECK_EN
        check("sweep_check_err", int'(check_err), 0);
`endif
      end
    end

    // Random operands, divide-by-zero included.
    for (int i = 0; i < 60; i++) begin
      int n, d;
      n = int'($urandom_range(0, MAXV));
      d = int'($urandom_range(0, MAXV));
      ref_div(n, d, eq, er, edbz);
      run_div(n, d, q, r, dbz, lat, bc);
      check("rand_q", q, eq);
      check("rand_r", r, er);
      check("rand_dbz", dbz, edbz);
      check("rand_lat", lat, (d == 0) ? 1 : W + 1);
    end

    // start during RUN is ignored.
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; dividend = 4'd6; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, lat, bc);
    check("ignore_lat", lat, 5);
    check("ignore_q", int'(quotient), 4);
    check("ignore_r", int'(remainder), 1);
    @(negedge clk);

    // Reset on cycle 3 of a run aborts it without done.
    start = 1'b1; dividend = 4'd11; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_q", int'(quotient), 0);
    check("abort_r", int'(remainder), 0);
    check("abort_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    run_div(11, 2, q, r, dbz, lat, bc);
    check("after_abort_q", q, 5);
    check("after_abort_r", r, 1);

    // start held high: back-to-back divisions every W+2 cycles.
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(negedge clk);
    dividend = 4'd14; divisor = 4'd4;
    lat1 = -1; lat2 = -1; q1 = -1; r1 = -1; q2 = -1; r2 = -1;
    for (int cyc = 1; cyc < 30; cyc++) begin
      if (done) begin
        if (lat1 < 0) begin
          lat1 = cyc; q1 = int'(quotient); r1 = int'(remainder);
        end else begin
          lat2 = cyc; q2 = int'(quotient); r2 = int'(remainder);
          start = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("b2b_lat1", lat1, W + 1);
    check("b2b_q1", q1, 4);
    check("b2b_r1", r1, 1);
    check("b2b_lat2", lat2, 2 * W + 3);
    check("b2b_q2", q2, 3);
    check("b2b_r2", r2, 2);
    @(negedge clk); @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative unsigned restoring divider; the inverse operation of the team's 4-bit array multiplier.
- Computes quotient and remainder of dividend / divisor, one quotient bit per clock.
- Uses a start/done handshake.
- Sits beside the multiplier in the arithmetic lab datapath; the optional self-check reuses a multiply to prove q*d + r == n.

Parameters:
WIDTH, 4, operand width in bits for dividend, divisor, quotient and remainder (legal range 2..16).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request pulse; sampled only in IDLE.
dividend  input  WIDTH  numerator; sampled with the accepted start.
divisor  input  WIDTH  denominator; sampled with the accepted start.
busy  output  1  high while a division is in progress (RUN state).
done  output  1  one-cycle pulse when results become valid.
quotient  output  WIDTH  result quotient; holds until the next accepted start.
remainder  output  WIDTH  result remainder; holds until the next accepted start.
div_by_zero  output  1  set with done when divisor was 0; holds with results.
check_err  output  1  present only with DIV_SELFCHECK_EN; see Optional Feature.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal counter and registers cleared. Reset mid-RUN aborts; no done is produced.
- States:
  - IDLE -> RUN: start=1 and divisor!=0.
  - IDLE -> FIN: start=1 and divisor==0.
  - RUN -> FIN: after WIDTH iterations.
  - FIN -> IDLE: unconditional, next cycle.
- Accept edge (IDLE, start=1):
  - Latch dividend into shift register N and divisor into D.
  - Clear partial remainder R (WIDTH+1 bits), set iteration count = WIDTH.
  - Clear div_by_zero and check_err.
- Each RUN cycle (restoring step):
  - T = {R[WIDTH-1:0], N[WIDTH-1]}.
  - N shifts left by one.
  - If T >= {0,D}: R = T - D, shift 1 into the quotient LSB. Else: R = T, shift 0.
  - Decrement count; when count reaches 1 this cycle, next state is FIN.
- busy=1 exactly in RUN.
- FIN cycle: done=1 for one cycle; quotient and remainder registers already hold final values on this cycle and hold until the next accepted start.
- Latency, from the accept edge to the done cycle:
  - Normal division: WIDTH+1 cycles (5 for WIDTH=4).
  - Divisor zero: 1 cycle.
- Divide by zero: quotient = all ones, remainder = dividend, div_by_zero=1; RUN is skipped.
- start while in RUN or FIN is ignored; operand changes outside the accept edge have no effect.
- start held high continuously: a new division is accepted on the first IDLE cycle after FIN, i.e. back-to-back throughput of one division per WIDTH+2 cycles.
- Arithmetic is unsigned throughout. Invariant: dividend == quotient*divisor + remainder, and remainder < divisor (when divisor != 0).

Optional Feature:
- Macro: DIV_SELFCHECK_EN.
- Defined:
  - Adds port check_err.
  - In FIN, combinationally computes quotient*divisor_latched + remainder at 2*WIDTH bits and compares it with the latched dividend, zero-extended.
  - On mismatch, or if remainder >= divisor, check_err=1, registered, and it holds with the results.
  - The check is skipped for divide-by-zero, so check_err=0 in that case.
- Not defined: no check_err port, no multiply logic; all other behaviour is identical.

Test Plan:
- WIDTH=4, rst_n low then high, no start -> busy=0, done=0, quotient=0, remainder=0, div_by_zero=0 indefinitely.
- start with 13/3 -> busy high for 4 cycles; done on cycle 5 after accept; quotient=4, remainder=1, div_by_zero=0; results held until the next start.
- Sweep: 15/1 -> 15 r0; 2/9 -> 0 r2; 15/15 -> 1 r0; 0/5 -> 0 r0; exhaustive 16x15 nonzero-divisor sweep against a reference model.
- start with 7/0 -> done on the next cycle, quotient=15, remainder=7, div_by_zero=1, busy never asserts; then start 9/2 -> div_by_zero clears, result 4 r1.
- Accept 13/3, pulse start with 6/2 on cycle 2 of RUN -> ignored, result 4 r1. Then assert rst_n low on cycle 3 of a new 11/2 run -> outputs immediately 0, no done; the next start 11/2 gives 5 r1.
- With DIV_SELFCHECK_EN, exhaustive sweep -> check_err always 0. Force a stuck-at on quotient bit 0 -> check_err=1 on the first odd-quotient result (e.g. 9/3 -> 3).
